label_definition_scanner: RTL and testbench
===========================================

// Module: label_definition_scanner
// PURPOSE
// Writer/responder side of the assembler label path. During the PC_MAPPING pass it scans the source
// character stream for label definitions ("name:" at line start) and records name->pc pairs in an
// internal table. It serves single-cycle lookups to the label-reference interpreter in later passes.
// Names use the shared packed format [NUMBER_LETTERS-1:0][4:0], where each letter is char[4:0].
// PARAMETERS
// NUMBER_LINES    256  max source instructions; pc width = $clog2(NUMBER_LINES)
// NUMBER_LETTERS  6    max letters per label name
// NUM_LABELS      8    label table entries
// PORTS
// clk_in              in   1                    system clock
// rst_in              in   1                    reset, asynchronous, active-high
// scan_enable         in   1                    high while assembler_state == PC_MAPPING
// new_line            in   1                    one-cycle pulse: next char starts a new source line
// new_character       in   1                    strobe: incoming_character valid this cycle
// incoming_character  in   8                    ASCII character
// pc                  in   $clog2(NUMBER_LINES) pc bound to a label defined on the current line
// label_valid         out  1                    one-cycle pulse: entry committed last edge
// label_name          out  NUMBER_LETTERS*5     name of last committed entry
// label_pc            out  $clog2(NUMBER_LINES) pc of last committed entry
// label_count         out  $clog2(NUM_LABELS)+1 valid entries in table
// error_flag          out  1                    sticky error
// error_code          out  2                    00 none, 01 TOO_LONG, 10 DUPLICATE, 11 FULL
// lookup_name         in   NUMBER_LETTERS*5     packed name to resolve
// lookup_hit          out  1                    combinational: lookup_name matches a valid entry
// lookup_pc           out  $clog2(NUMBER_LINES) combinational: pc of matching entry, else 0
// BEHAVIOUR
// - Reset (async): state IDLE; table, label_count, label_name, label_pc, error_code = 0.
//   label_valid and error_flag = 0.
// - Letter = a-z or A-Z, packed as char[4:0], so matching is case-insensitive.
// - Shift on letter: name <= {name[NUMBER_LETTERS-2:0], char[4:0]}. The newest letter is in slot 0.
//   Unused upper slots are 0.
// - States:
//   IDLE: on a space or tab, stay. On a letter, clear name, load the letter, set len=1, go to NAME.
//     On any other character, go to SKIP.
//   NAME: on a letter, shift it in if len<NUMBER_LETTERS; otherwise set the overflow flag and keep
//     the name. On ':', run the commit check. On any other character, go to SKIP (the word was a
//     mnemonic, not a label).
//   SKIP: ignore all characters until new_line.
//   ERROR: absorbing. Ignore all input until rst_in. The table is still readable.
// - Commit check on ':'. Priority: overflow -> ERROR/01; else name already in table -> ERROR/10;
//   else label_count==NUM_LABELS -> ERROR/11.
//   Otherwise, at the same edge: write {name, pc} to index label_count, increment label_count, and
//   register label_name/label_pc. Go to SKIP.
// - label_valid is high for exactly the one cycle after the ':' edge (latency 1).
// - The duplicate check compares only entries with index < label_count.
// - new_line: any non-ERROR state -> IDLE. A partial NAME without ':' is discarded, no write.
// - new_line and new_character in the same cycle: new_line wins and the character is dropped.
// - new_character low: state holds; label_valid falls to 0.
// - scan_enable low: non-ERROR state forced to IDLE, no writes. The table and label_count are
//   retained, and lookups remain valid.
// - error_flag is asserted on the edge that enters ERROR. error_code holds until reset.
// - Lookup is purely combinational over valid entries. Duplicates cannot exist, so a hit is unique.
// - Reset asserted mid-NAME: outputs clear immediately without waiting for a clock. No partial entry
//   is written.
// TESTING
// 1. "loop:" + new_line, pc=5 -> label_valid high 1 cycle after ':'; label_name={0,0,0C,0F,0F,10};
//    label_pc=5; label_count=1; then lookup "loop" -> hit=1, lookup_pc=5.
// 2. "addi x1, x0, 3" -> NAME then SKIP on ' '; no label_valid; label_count unchanged;
//    lookup "addi" -> hit=0, pc=0.
// 3. 8 distinct labels "a:".."h:" then "zz:" -> count=8; error_flag=1, code=11; lookups of a..h hit.
// 4. "loop:" then "LOOP:" -> second gives error_flag=1, code=10; label_count stays 1.
// 5. "abcdefg:" -> error code 01, nothing written. Also "abcdefgh x" -> SKIP with no error.
// 6. rst_in pulsed between clock edges mid-NAME -> all outputs 0 before the next edge.
//    new_line with new_character 'q' in the same cycle -> 'q' dropped, state IDLE.

Source files
------------

// File: rtl/label_definition_scanner_if.sv
// Character-stream, commit and lookup signals of the assembler label table.
interface label_definition_scanner_if #(
  parameter int unsigned NUMBER_LINES   = 256,
  parameter int unsigned NUMBER_LETTERS = 6,
  parameter int unsigned NUM_LABELS     = 8
);
  localparam int unsigned PC_W    = $clog2(NUMBER_LINES);
  localparam int unsigned NAME_W  = NUMBER_LETTERS * 5;
  localparam int unsigned COUNT_W = $clog2(NUM_LABELS) + 1;

  logic               scan_enable;
  logic               new_line;
  logic               new_character;
  logic [7:0]         incoming_character;
  logic [PC_W-1:0]    pc;
  logic               label_valid;
  logic [NAME_W-1:0]  label_name;
  logic [PC_W-1:0]    label_pc;
  logic [COUNT_W-1:0] label_count;
  logic               error_flag;
  logic [1:0]         error_code;
  logic [NAME_W-1:0]  lookup_name;
  logic               lookup_hit;
  logic [PC_W-1:0]    lookup_pc;

  modport master (
    output scan_enable, new_line, new_character, incoming_character, pc, lookup_name,
    input  label_valid, label_name, label_pc, label_count, error_flag, error_code,
           lookup_hit, lookup_pc
  );

  modport slave (
    input  scan_enable, new_line, new_character, incoming_character, pc, lookup_name,
    output label_valid, label_name, label_pc, label_count, error_flag, error_code,
           lookup_hit, lookup_pc
  );
endinterface

// File: rtl/label_definition_scanner.sv
// Scans source characters for "name:" label definitions, stores name->pc pairs,
// and answers combinational name lookups.
module label_definition_scanner #(
  parameter int unsigned NUMBER_LINES   = 256,
  parameter int unsigned NUMBER_LETTERS = 6,
  parameter int unsigned NUM_LABELS     = 8
) (
  input logic clk_in,
  input logic rst_in,
  label_definition_scanner_if.slave bus
);
  localparam int unsigned PC_W    = $clog2(NUMBER_LINES);
  localparam int unsigned NAME_W  = NUMBER_LETTERS * 5;
  localparam int unsigned COUNT_W = $clog2(NUM_LABELS) + 1;
  localparam int unsigned IDX_W   = $clog2(NUM_LABELS);
  localparam int unsigned LEN_W   = $clog2(NUMBER_LETTERS + 1);

  localparam logic [1:0] ERR_TOO_LONG  = 2'b01;
  localparam logic [1:0] ERR_DUPLICATE = 2'b10;
  localparam logic [1:0] ERR_FULL      = 2'b11;

  typedef enum logic [1:0] {IDLE, NAME, SKIP, ERROR} state_t;

  state_t                        state;
  logic [NUMBER_LETTERS-1:0][4:0] name;
  logic [LEN_W-1:0]              len;
  logic                          overflow;
  logic [COUNT_W-1:0]            count;
  logic [NAME_W-1:0]             tab_name [NUM_LABELS];
  logic [PC_W-1:0]               tab_pc   [NUM_LABELS];
  logic                          valid_q;
  logic [NAME_W-1:0]             name_q;
  logic [PC_W-1:0]               pc_q;
  logic                          err_flag_q;
  logic [1:0]                    err_code_q;
  logic                          dup_c;
  logic                          hit_c;
  logic [PC_W-1:0]               hit_pc_c;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
  endfunction

  wire [7:0] ch = bus.incoming_character;
  wire       ch_letter = is_letter(ch);
  wire       ch_blank  = (ch == 8'h20) || (ch == 8'h09);
  wire       ch_colon  = (ch == 8'h3A);

  // Duplicate detection and lookup only consider committed entries.
  always_comb begin
    dup_c    = 1'b0;
    hit_c    = 1'b0;
    hit_pc_c = '0;
    for (int i = 0; i < int'(NUM_LABELS); i++) begin
      if (COUNT_W'(i) < count) begin
        if (tab_name[i] == NAME_W'(name)) dup_c = 1'b1;
        if (tab_name[i] == bus.lookup_name) begin
          hit_c    = 1'b1;
          hit_pc_c = tab_pc[i];
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      name       <= '0;
      len        <= '0;
      overflow   <= 1'b0;
      count      <= '0;
      valid_q    <= 1'b0;
      name_q     <= '0;
      pc_q       <= '0;
      err_flag_q <= 1'b0;
      err_code_q <= 2'b00;
      for (int i = 0; i < int'(NUM_LABELS); i++) begin
        tab_name[i] <= '0;
        tab_pc[i]   <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      if (state != ERROR) begin
        // new_line wins over a simultaneous character.
        if (!bus.scan_enable || bus.new_line) begin
          state <= IDLE;
        end else if (bus.new_character) begin
          unique case (state)
            IDLE: begin
              if (ch_letter) begin
                name     <= NAME_W'(ch[4:0]);
                len      <= LEN_W'(1);
                overflow <= 1'b0;
                state    <= NAME;
              end else if (!ch_blank) begin
                state <= SKIP;
              end
            end
            NAME: begin
              if (ch_letter) begin
                if (len < LEN_W'(NUMBER_LETTERS)) begin
                  name <= {name[NUMBER_LETTERS-2:0], ch[4:0]};
                  len  <= len + LEN_W'(1);
                end else begin
                  overflow <= 1'b1;
                end
              end else if (ch_colon) begin
                if (overflow) begin
                  state      <= ERROR;
                  err_flag_q <= 1'b1;
                  err_code_q <= ERR_TOO_LONG;
                end else if (dup_c) begin
                  state      <= ERROR;
                  err_flag_q <= 1'b1;
                  err_code_q <= ERR_DUPLICATE;
                end else if (count == COUNT_W'(NUM_LABELS)) begin
                  state      <= ERROR;
                  err_flag_q <= 1'b1;
                  err_code_q <= ERR_FULL;
                end else begin
                  tab_name[count[IDX_W-1:0]] <= NAME_W'(name);
                  tab_pc[count[IDX_W-1:0]]   <= bus.pc;
                  count   <= count + COUNT_W'(1);
                  name_q  <= NAME_W'(name);
                  pc_q    <= bus.pc;
                  valid_q <= 1'b1;
                  state   <= SKIP;
                end
              end else begin
                state <= SKIP;
              end
            end
            SKIP:    state <= SKIP;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.label_valid = valid_q;
  assign bus.label_name  = name_q;
  assign bus.label_pc    = pc_q;
  assign bus.label_count = count;
  assign bus.error_flag  = err_flag_q;
  assign bus.error_code  = err_code_q;
  assign bus.lookup_hit  = hit_c;
  assign bus.lookup_pc   = hit_pc_c;
endmodule

// File: tb/tb_label_definition_scanner.sv
// Scoreboard bench: expected commits are queued at stimulus time and checked by a
// monitor whenever label_valid is seen; table state and errors are checked directly.
module tb_label_definition_scanner;
  localparam int unsigned NL = 256;
  localparam int unsigned NLET = 6;
  localparam int unsigned NLAB = 8;

  localparam logic [29:0] N_LOOP = {5'h00, 5'h00, 5'h0C, 5'h0F, 5'h0F, 5'h10};
  localparam logic [29:0] N_ADDI = {5'h00, 5'h00, 5'h01, 5'h04, 5'h04, 5'h09};
  localparam logic [29:0] N_R    = {25'h0, 5'h12};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  label_definition_scanner_if #(.NUMBER_LINES(NL), .NUMBER_LETTERS(NLET), .NUM_LABELS(NLAB)) bus ();

  label_definition_scanner #(.NUMBER_LINES(NL), .NUMBER_LETTERS(NLET), .NUM_LABELS(NLAB)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  typedef struct {
    logic [29:0] name;
    logic [7:0]  pc;
    logic [3:0]  count;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", what, act, exp, $time);
    end
  endtask

  // Monitor: every label_valid cycle must match the oldest expected commit.
  always @(negedge clk) begin
    if (!rst && bus.label_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_label_valid: got name %0h expected no commit", bus.label_name);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("commit_name", 32'(bus.label_name), 32'(e.name));
        chk("commit_pc", 32'(bus.label_pc), 32'(e.pc));
        chk("commit_count", 32'(bus.label_count), 32'(e.count));
      end
    end
  end

  task automatic put(input logic [7:0] c);
    bus.incoming_character = c;
    bus.new_character = 1'b1;
    @(posedge clk); #1;
    bus.new_character = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic nl();
    bus.new_line = 1'b1;
    @(posedge clk); #1;
    bus.new_line = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL commit_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic lookup(input string what, input logic [29:0] n, input logic hit, input logic [7:0] pc);
    bus.lookup_name = n;
    #1;
    chk({what, "_hit"}, 32'(bus.lookup_hit), 32'(hit));
    chk({what, "_pc"}, 32'(bus.lookup_pc), 32'(pc));
  endtask

  initial begin
    logic [7:0] c;
    bus.scan_enable = 1'b1;
    bus.new_line = 1'b0;
    bus.new_character = 1'b0;
    bus.incoming_character = 8'h00;
    bus.pc = 8'd0;
    bus.lookup_name = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.label_valid), 32'd0);
    chk("rst_count", 32'(bus.label_count), 32'd0);
    chk("rst_name", 32'(bus.label_name), 32'd0);
    chk("rst_pc", 32'(bus.label_pc), 32'd0);
    chk("rst_eflag", 32'(bus.error_flag), 32'd0);
    chk("rst_ecode", 32'(bus.error_code), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single label definition and lookup.
    bus.pc = 8'd5;
    q.push_back('{N_LOOP, 8'd5, 4'd1});
    send("loop:");
    nl();
    drain();
    lookup("lk_loop", N_LOOP, 1'b1, 8'd5);

    // Mnemonic line must not define a label.
    send("addi x1, x0, 3");
    nl();
    chk("mnem_count", 32'(bus.label_count), 32'd1);
    chk("mnem_eflag", 32'(bus.error_flag), 32'd0);
    lookup("lk_addi", N_ADDI, 1'b0, 8'd0);

    // Case-insensitive duplicate.
    send("LOOP:");
    chk("dup_eflag", 32'(bus.error_flag), 32'd1);
    chk("dup_ecode", 32'(bus.error_code), 32'd2);
    chk("dup_count", 32'(bus.label_count), 32'd1);
    lookup("lk_after_dup", N_LOOP, 1'b1, 8'd5);

    do_reset();
    chk("rst2_count", 32'(bus.label_count), 32'd0);
    lookup("lk_cleared", N_LOOP, 1'b0, 8'd0);

    // Fill the table, then overflow it.
    for (int i = 0; i < 8; i++) begin
      bus.pc = 8'(20 + i);
      c = 8'h61 + 8'(i);
      q.push_back('{30'(i + 1), 8'(20 + i), 4'(i + 1)});
      put(c);
      put(8'h3A);
      nl();
      drain();
    end
    chk("full_count", 32'(bus.label_count), 32'd8);
    chk("full_pre_eflag", 32'(bus.error_flag), 32'd0);
    bus.pc = 8'd99;
    send("zz:");
    chk("full_eflag", 32'(bus.error_flag), 32'd1);
    chk("full_ecode", 32'(bus.error_code), 32'd3);
    chk("full_count2", 32'(bus.label_count), 32'd8);
    for (int i = 0; i < 8; i++) lookup("lk_fill", 30'(i + 1), 1'b1, 8'(20 + i));

    do_reset();

    // Over-long words: mnemonic is harmless, label is an error.
    send("abcdefgh x");
    nl();
    chk("long_word_eflag", 32'(bus.error_flag), 32'd0);
    chk("long_word_count", 32'(bus.label_count), 32'd0);
    send("abcdefg:");
    chk("long_lab_eflag", 32'(bus.error_flag), 32'd1);
    chk("long_lab_ecode", 32'(bus.error_code), 32'd1);
    chk("long_lab_count", 32'(bus.label_count), 32'd0);

    do_reset();

    // new_line with a character in the same cycle drops the character.
    send("x y");
    bus.new_line = 1'b1;
    bus.new_character = 1'b1;
    bus.incoming_character = 8'h71;
    @(posedge clk); #1;
    bus.new_line = 1'b0;
    bus.new_character = 1'b0;
    bus.pc = 8'd7;
    q.push_back('{N_R, 8'd7, 4'd1});
    send("r:");
    drain();
    nl();

    // Asynchronous reset in the middle of a name.
    send("ab");
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(bus.label_count), 32'd0);
    chk("arst_name", 32'(bus.label_name), 32'd0);
    chk("arst_pc", 32'(bus.label_pc), 32'd0);
    chk("arst_valid", 32'(bus.label_valid), 32'd0);
    chk("arst_eflag", 32'(bus.error_flag), 32'd0);
    chk("arst_ecode", 32'(bus.error_code), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(":");
    nl();
    chk("arst_after_count", 32'(bus.label_count), 32'd0);
    lookup("lk_arst", N_R, 1'b0, 8'd0);

    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
